// File: rtl/store_lane_packer_pkg.sv
// Shared types and constants for the store lane packer: size encodings,
// the all-lanes byte-enable and the layout of one buffered store entry.
package store_pkg;

    // Store access size as carried on st_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // All four byte lanes enabled (full-word store).
    localparam logic [3:0] BE_ALL = 4'b1111;

    // One packed store waiting for memory: word address, lane-replicated
    // data and per-lane byte enables.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

endpackage

// File: rtl/store_lane_packer_if.sv
// Bus bundle between the execute/memory stage (store request side), the
// data memory (head-entry side) and the exception logic (misalign report).
// master = the environment driving requests and memory ready,
// slave  = the packer itself.
interface store_lane_packer_if #(
    parameter int CNT_W = 2
);

    // Store request side
    logic              st_valid;
    logic              st_ready;
    logic [31:0]       st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;

    // Memory side
    logic              mem_valid;
    logic              mem_ready;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;

    // Exception report and status
    logic              misalign;
    logic [31:0]       misalign_addr;
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ready,
        input  st_ready, mem_valid, mem_addr, mem_wdata, mem_be,
        input  misalign, misalign_addr, count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ready,
        output st_ready, mem_valid, mem_addr, mem_wdata, mem_be,
        output misalign, misalign_addr, count, empty
    );

endinterface

// File: rtl/store_lane_packer_lane_map.sv
// Combinational lane mapper: places the low byte / half / full register
// value onto the little-endian byte lanes of a 32-bit word, produces the
// matching byte enables and decides whether the access is aligned.
module store_lane_map
    import store_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_data,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic        o_legal
);

    // Replicate the source across lanes so the enabled lanes always carry
    // the right bytes regardless of offset; enables select the real target.
    always_comb begin
        o_wdata = i_data;
        o_be    = 4'b0000;
        o_legal = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_wdata = {4{i_data[7:0]}};
                o_be    = 4'b0001 << i_addr;
                o_legal = 1'b1;
            end
            SZ_HALF: begin
                o_wdata = {2{i_data[15:0]}};
                o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                o_legal = ~i_addr[0];
            end
            SZ_WORD: begin
                o_wdata = i_data;
                o_be    = BE_ALL;
                o_legal = (i_addr == 2'b00);
            end
            default: begin
                o_wdata = i_data;
                o_be    = 4'b0000;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_lane_packer.sv
// Store lane packer: packs SB/SH/SW requests into byte lanes, buffers up to
// DEPTH of them in program order in front of the data memory, and reports
// misaligned requests to the exception logic instead of enqueuing them.
// The mem_* outputs come from a dedicated head register so they hold steady
// through memory stalls and keep their last value once the buffer drains.
module store_lane_packer
    import store_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    store_lane_packer_if.slave  bus
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage and control state
    entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    entry_t            r_head;
    logic              r_misalign;
    logic [31:0]       r_misalign_addr;

    // Request-side decode
    logic [31:0]       w_wdata;
    logic [3:0]        w_be;
    logic              w_legal;
    logic              w_st_ready;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    entry_t            w_new_entry;

    // Next-state helpers
    logic [CNT_W-1:0]  w_count_after_pop;
    logic [CNT_W-1:0]  w_count_next;
    logic [PTR_W-1:0]  w_rptr_next;

    store_lane_map u_lane_map (
        .i_addr  (bus.st_addr[1:0]),
        .i_size  (bus.st_size),
        .i_data  (bus.st_data),
        .o_wdata (w_wdata),
        .o_be    (w_be),
        .o_legal (w_legal)
    );

    // Ready depends only on registered occupancy: a pop in the same cycle
    // does not open a slot until the next cycle, so mem_ready never reaches
    // st_ready combinationally.
    assign w_st_ready  = (r_count != FULL_CNT);
    assign w_accept    = bus.st_valid & w_st_ready;
    assign w_push      = w_accept & w_legal;
    assign w_pop       = (r_count != '0) & bus.mem_ready;
    assign w_new_entry = {bus.st_addr[31:2], 2'b00, w_wdata, w_be};

    assign w_count_after_pop = r_count - CNT_W'(w_pop);
    assign w_count_next      = w_count_after_pop + CNT_W'(w_push);
    assign w_rptr_next       = r_rptr + PTR_W'(w_pop);

    // Entry storage: written on every legal accepted store; contents are
    // only ever read while valid, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_new_entry;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a
    // power of two, full/empty are taken from the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            r_rptr  <= w_rptr_next;
            r_count <= w_count_next;
        end
    end

    // Head register: loads whatever will be at the front next cycle. When
    // the buffer is (or becomes) empty apart from the incoming store, the
    // store bypasses storage, since its slot is being written this very
    // edge. While stalled the same entry is reloaded, so outputs stay put;
    // once empty the register simply holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
        end else if (w_count_next != '0) begin
            if (w_push && (w_count_after_pop == '0)) begin
                r_head <= w_new_entry;
            end else begin
                r_head <= r_mem[w_rptr_next];
            end
        end
    end

    // Misalign report: one-cycle pulse per rejected request, address held
    // until the next rejection. Requests refused by st_ready are not judged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign <= w_accept & ~w_legal;
            if (w_accept && !w_legal) begin
                r_misalign_addr <= bus.st_addr;
            end
        end
    end

    assign bus.st_ready      = w_st_ready;
    assign bus.mem_valid     = (r_count != '0);
    assign bus.empty         = (r_count == '0);
    assign bus.count         = r_count;
    assign bus.mem_addr      = r_head.addr;
    assign bus.mem_wdata     = r_head.wdata;
    assign bus.mem_be        = r_head.be;
    assign bus.misalign      = r_misalign;
    assign bus.misalign_addr = r_misalign_addr;

endmodule

// File: tb/tb_store_lane_packer.sv
// Bench for store_lane_packer: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_store_lane_packer;

    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    store_lane_packer_if #(.CNT_W(CNT_W)) bus ();

    store_lane_packer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: queue of {word addr, wdata, be} in order.
    logic [67:0] q [$];
    logic        exp_mis;
    logic [31:0] exp_mis_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected packing from the little-endian lane rules.
    function automatic logic [67:0] model_pack(input logic [31:0] a, input logic [31:0] d,
                                               input logic [1:0] sz, output bit legal);
        logic [31:0] wd;
        logic [3:0]  be;
        legal = 1'b0;
        wd    = 32'h0;
        be    = 4'h0;
        case (sz)
            2'd0: begin
                legal = 1'b1;
                wd    = {24'h0, d[7:0]} * 32'h0101_0101;
                be    = 4'(1 << (a % 4));
            end
            2'd1: begin
                legal = (a % 2 == 0);
                wd    = {16'h0, d[15:0]} * 32'h0001_0001;
                be    = ((a % 4) >= 2) ? 4'hC : 4'h3;
            end
            2'd2: begin
                legal = (a % 4 == 0);
                wd    = d;
                be    = 4'hF;
            end
            default: legal = 1'b0;
        endcase
        return {a & 32'hFFFF_FFFC, wd, be};
    endfunction

    task automatic check_outputs();
        logic [67:0] h;
        chk("count",     32'(bus.count),     32'(q.size()));
        chk("empty",     32'(bus.empty),     32'(q.size() == 0));
        chk("mem_valid", 32'(bus.mem_valid), 32'(q.size() != 0));
        chk("misalign",  32'(bus.misalign),  32'(exp_mis));
        chk("mis_addr",  bus.misalign_addr,  exp_mis_addr);
        if (q.size() != 0) begin
            h = q[0];
            chk("mem_addr",  bus.mem_addr,        h[67:36]);
            chk("mem_wdata", bus.mem_wdata,       h[35:4]);
            chk("mem_be",    32'(bus.mem_be),     32'(h[3:0]));
        end
    endtask

    // One clock: drive at negedge, check ready, update model at posedge,
    // check registered outputs just after.
    task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input bit mr, output bit acc);
        bit          legal;
        bit          rdy_exp;
        logic [67:0] e;
        logic [67:0] dropped;
        @(negedge clk);
        rst           = 1'b0;
        bus.st_valid  = v;
        bus.st_addr   = a;
        bus.st_data   = d;
        bus.st_size   = sz;
        bus.mem_ready = mr;
        #1;
        rdy_exp = (q.size() != DEPTH);
        chk("st_ready", 32'(bus.st_ready), 32'(rdy_exp));
        e   = model_pack(a, d, sz, legal);
        acc = v && rdy_exp;
        @(posedge clk);
        if (q.size() != 0 && mr) dropped = q.pop_front();
        exp_mis = acc && !legal;
        if (acc && !legal) exp_mis_addr = a;
        if (acc && legal) q.push_back(e);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.st_valid  = 1'b1;
        bus.st_addr   = 32'h0000_0001;
        bus.st_data   = 32'h1111_1111;
        bus.st_size   = 2'b10;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        q.delete();
        exp_mis      = 1'b0;
        exp_mis_addr = 32'h0;
        #1;
        check_outputs();
        chk("rst_st_ready",  32'(bus.st_ready), 32'd1);
        chk("rst_mem_addr",  bus.mem_addr,      32'h0);
        chk("rst_mem_wdata", bus.mem_wdata,     32'h0);
        chk("rst_mem_be",    32'(bus.mem_be),   32'h0);
    endtask

    initial begin
        bit acc;
        int tries;
        rst           = 1'b1;
        bus.st_valid  = 1'b0;
        bus.st_addr   = 32'h0;
        bus.st_data   = 32'h0;
        bus.st_size   = 2'b00;
        bus.mem_ready = 1'b0;
        exp_mis       = 1'b0;
        exp_mis_addr  = 32'h0;

        do_reset();

        // SB into the top lane
        cycle(1, 32'h1000_0003, 32'hAABB_CCDD, 2'b00, 1, acc);
        chk("sb_addr",  bus.mem_addr,      32'h1000_0000);
        chk("sb_wdata", bus.mem_wdata,     32'hDDDD_DDDD);
        chk("sb_be",    32'(bus.mem_be),   32'h8);
        cycle(0, 32'h0, 32'h0, 2'b00, 1, acc);
        chk("sb_empty", 32'(bus.empty),    32'd1);

        // SH upper half, then SW
        cycle(1, 32'h0000_2002, 32'h1234_5678, 2'b01, 1, acc);
        chk("sh_wdata", bus.mem_wdata,     32'h5678_5678);
        chk("sh_be",    32'(bus.mem_be),   32'hC);
        cycle(1, 32'h0000_2004, 32'hCAFE_F00D, 2'b10, 1, acc);
        chk("sw_wdata", bus.mem_wdata,     32'hCAFE_F00D);
        chk("sw_be",    32'(bus.mem_be),   32'hF);
        cycle(0, 32'h0, 32'h0, 2'b00, 1, acc);

        // Misaligned and illegal requests
        cycle(1, 32'h0000_2001, 32'h5555_5555, 2'b01, 1, acc);
        chk("mis_sh",      32'(bus.misalign), 32'd1);
        chk("mis_sh_addr", bus.misalign_addr, 32'h0000_2001);
        cycle(1, 32'h0000_3002, 32'h6666_6666, 2'b10, 1, acc);
        chk("mis_sw_addr", bus.misalign_addr, 32'h0000_3002);
        cycle(1, 32'h0000_0000, 32'h7777_7777, 2'b11, 1, acc);
        chk("mis_ill_addr", bus.misalign_addr, 32'h0000_0000);
        cycle(0, 32'h0, 32'h0, 2'b00, 1, acc);
        chk("mis_clear",   32'(bus.misalign), 32'd0);

        // Back-pressure: fill, third blocked, accepted the cycle after a pop
        cycle(1, 32'h0000_4000, 32'hA0A0_A0A0, 2'b10, 0, acc);
        cycle(1, 32'h0000_4005, 32'hB1B1_B1B1, 2'b00, 0, acc);
        chk("bp_count", 32'(bus.count), 32'd2);
        cycle(1, 32'h0000_4006, 32'hC2C2_C2C2, 2'b01, 0, acc);
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 4) begin
            tries++;
            cycle(1, 32'h0000_4006, 32'hC2C2_C2C2, 2'b01, 1, acc);
        end
        chk("bp_third_try", 32'(tries), 32'd2);
        repeat (3) cycle(0, 32'h0, 32'h0, 2'b00, 1, acc);

        // Reset with two buffered entries and a stalled head
        cycle(1, 32'h0000_5000, 32'h0102_0304, 2'b10, 0, acc);
        cycle(1, 32'h0000_5004, 32'h0506_0708, 2'b10, 0, acc);
        do_reset();
        cycle(1, 32'h0000_6008, 32'h89AB_CDEF, 2'b10, 1, acc);
        chk("post_rst_wdata", bus.mem_wdata, 32'h89AB_CDEF);
        cycle(0, 32'h0, 32'h0, 2'b00, 1, acc);

        // Randomized traffic with bursty memory stalls
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 3) != 0), $urandom, $urandom,
                      2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0), acc);
            end
        end
        repeat (4) cycle(0, 32'h0, 32'h0, 2'b00, 1, acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
